// File: rtl/mult_table_pkg.sv
// mult_table_pkg -- shared types for the multiple-table generator.
//   state_t   : build FSM states (IDLE, CALC)
//   tbl_idx_t : table index / build counter, wide enough for the
//               largest legal PBITS (6, so index 0..64)
//   mlsize()  : table depth 2^pbits
package mult_table_pkg;

  localparam int MAX_PBITS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  typedef logic [MAX_PBITS:0] tbl_idx_t;

  function automatic int mlsize(input int pbits);
    return 1 << pbits;
  endfunction

endpackage

// File: rtl/mult_table_gen_mod_add_red.sv
// mod_add_red -- combinational (a + b) mod m for operands already < m.
// A single conditional subtraction of m is enough because a + b < 2m.
//   a, b : addends, each < m
//   m    : modulus
//   sum  : (a + b) mod m
module mod_add_red #(
  parameter int NBITS = 256
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] sum
);

  logic [NBITS:0] raw;
  logic [NBITS:0] red;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    red = raw - {1'b0, m};
    // red is only kept when raw >= m, i.e. the subtraction did not wrap
    if (raw >= {1'b0, m}) sum = NBITS'(red);
    else                  sum = NBITS'(raw);
  end

endmodule

// File: rtl/mult_table_gen.sv
// mult_table_gen -- builds tables of k*m and (k*b) mod m, k = 0..MLSIZE,
// by sequential accumulation, one entry per clock.
//   clk, rst_n    : clock, async active-low reset
//   start         : build request, accepted only in IDLE
//   m, b          : modulus and multiplicand (b < m), captured on accept
//   busy          : high while building
//   done          : one-cycle pulse after the last entry is written
//   valid         : table matches the captured m, b
//   rd_idx        : combinational read index, >MLSIZE reads as zero
//   mxn_rd        : rd_idx*m
//   bxn_rd        : (rd_idx*b) mod m
// Macro MULT_TABLE_BXN_EN: when defined the b-multiple table is built;
// when undefined bxn_rd is tied to zero and no b state exists.
module mult_table_gen
  import mult_table_pkg::*;
#(
  parameter int NBITS = 256,
  parameter int PBITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NBITS-1:0]       m,
  input  logic [NBITS-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  input  logic [PBITS:0]         rd_idx,
  output logic [NBITS+PBITS-1:0] mxn_rd,
  output logic [NBITS-1:0]       bxn_rd
);

  localparam int MLSIZE = mlsize(PBITS);
  localparam int MW     = NBITS + PBITS;

  state_t           state;
  tbl_idx_t         cnt;
  logic [NBITS-1:0] m_q;
  // entries 0 and 1 need no storage: 0 and the captured operand
  logic [MW-1:0]    mxn_q [2:MLSIZE];
  logic [MW-1:0]    mxn_prev;
  logic [MW-1:0]    mxn_next;
  logic             last;
  tbl_idx_t         rd;

  assign last = (cnt == tbl_idx_t'(MLSIZE));
  assign rd   = tbl_idx_t'(rd_idx);

  // entry cnt-1 feeds the accumulator
  always_comb begin
    mxn_prev = {{PBITS{1'b0}}, m_q};
    for (int i = 2; i < MLSIZE; i++)
      if (cnt == tbl_idx_t'(i + 1)) mxn_prev = mxn_q[i];
    mxn_next = mxn_prev + {{PBITS{1'b0}}, m_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      m_q   <= '0;
      for (int i = 2; i <= MLSIZE; i++) mxn_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_q   <= m;
          valid <= 1'b0;
          busy  <= 1'b1;
          cnt   <= tbl_idx_t'(2);
          state <= CALC;
        end
        CALC: begin
          for (int i = 2; i <= MLSIZE; i++)
            if (cnt == tbl_idx_t'(i)) mxn_q[i] <= mxn_next;
          cnt <= cnt + tbl_idx_t'(1);
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b1;
            done  <= 1'b1;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mxn_rd = '0;
    if (rd == tbl_idx_t'(1)) mxn_rd = {{PBITS{1'b0}}, m_q};
    for (int i = 2; i <= MLSIZE; i++)
      if (rd == tbl_idx_t'(i)) mxn_rd = mxn_q[i];
  end

`ifdef MULT_TABLE_BXN_EN
  logic [NBITS-1:0] b_q;
  logic [NBITS-1:0] bxn_q [2:MLSIZE];
  logic [NBITS-1:0] bxn_prev;
  logic [NBITS-1:0] bxn_next;

  always_comb begin
    bxn_prev = b_q;
    for (int i = 2; i < MLSIZE; i++)
      if (cnt == tbl_idx_t'(i + 1)) bxn_prev = bxn_q[i];
  end

  mod_add_red #(.NBITS(NBITS)) u_add_red (
    .a   (bxn_prev),
    .b   (b_q),
    .m   (m_q),
    .sum (bxn_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q <= '0;
      for (int i = 2; i <= MLSIZE; i++) bxn_q[i] <= '0;
    end else if (state == IDLE) begin
      if (start) b_q <= b;
    end else begin
      for (int i = 2; i <= MLSIZE; i++)
        if (cnt == tbl_idx_t'(i)) bxn_q[i] <= bxn_next;
    end
  end

  always_comb begin
    bxn_rd = '0;
    if (rd == tbl_idx_t'(1)) bxn_rd = b_q;
    for (int i = 2; i <= MLSIZE; i++)
      if (rd == tbl_idx_t'(i)) bxn_rd = bxn_q[i];
  end
`else
  logic unused_b;
  assign unused_b = ^b;
  assign bxn_rd   = '0;
`endif

endmodule

// File: tb/tb_mult_table_gen.sv
// tb_mult_table_gen -- randomized self-checking bench for mult_table_gen.
// Two instances: NBITS=8/PBITS=2 (main) and NBITS=8/PBITS=1.
// Expected tables come from plain arithmetic: k*m and (k*b) mod m
// (zero when MULT_TABLE_BXN_EN is undefined).
module tb_mult_table_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] m = '0, b = '0;
  logic       busy, done, valid;
  logic [2:0] rd_idx = '0;
  logic [9:0] mxn_rd;
  logic [7:0] bxn_rd;

  logic       start1 = 1'b0;
  logic [7:0] m1 = '0, b1 = '0;
  logic       busy1, done1, valid1;
  logic [1:0] rd_idx1 = '0;
  logic [8:0] mxn_rd1;
  logic [7:0] bxn_rd1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult_table_gen #(.NBITS(8), .PBITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .b(b),
    .busy(busy), .done(done), .valid(valid),
    .rd_idx(rd_idx), .mxn_rd(mxn_rd), .bxn_rd(bxn_rd)
  );

  mult_table_gen #(.NBITS(8), .PBITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .m(m1), .b(b1),
    .busy(busy1), .done(done1), .valid(valid1),
    .rd_idx(rd_idx1), .mxn_rd(mxn_rd1), .bxn_rd(bxn_rd1)
  );

  function automatic int exp_mxn(input int k, input int mm, input int depth);
    return (k <= depth) ? k * mm : 0;
  endfunction

  function automatic int exp_bxn(input int k, input int mm, input int bb, input int depth);
`ifdef MULT_TABLE_BXN_EN
    return (k <= depth && mm != 0) ? (k * bb) % mm : 0;
`else
    return 0;
`endif
  endfunction

  // drive one start pulse on the main instance and count edges to done
  task automatic build0(input int mm, input int bb, output int lat);
    @(negedge clk); start = 1'b1; m = 8'(mm); b = 8'(bb);
    @(negedge clk); start = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done, valid} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got %b want 000", {busy, done, valid}); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'd0 || bxn_rd !== 8'd0) begin n_fail++;
        $display("FAIL reset_read idx=%0d got %0d/%0d want 0/0", i, mxn_rd, bxn_rd); end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    build0(13, 5, lat);
    n_chk++; if (lat !== 3) begin n_fail++;
      $display("FAIL basic_latency got %0d want 3", lat); end
    n_chk++; if ({busy, valid} !== 2'b01) begin n_fail++;
      $display("FAIL basic_flags got busy,valid=%b want 01", {busy, valid}); end
    @(negedge clk);
    n_chk++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL basic_done_pulse got %b want 0", done); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(i, 13, 4)) || bxn_rd !== 8'(exp_bxn(i, 13, 5, 4))) begin
        n_fail++; $display("FAIL basic_table idx=%0d got %0d/%0d want %0d/%0d", i, mxn_rd, bxn_rd,
          exp_mxn(i, 13, 4), exp_bxn(i, 13, 5, 4)); end
    end
  endtask

  task automatic test_pbits1;
    int lat;
    @(negedge clk); start1 = 1'b1; m1 = 8'd255; b1 = 8'd254;
    @(negedge clk); start1 = 1'b0; lat = 0;
    n_chk++; if (busy1 !== 1'b1) begin n_fail++;
      $display("FAIL p1_busy got %b want 1", busy1); end
    while (done1 !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_chk++; if (lat !== 1 || valid1 !== 1'b1) begin n_fail++;
      $display("FAIL p1_latency got lat=%0d valid=%b want 1/1", lat, valid1); end
    for (int i = 0; i < 4; i++) begin
      rd_idx1 = 2'(i); #1;
      n_chk++; if (mxn_rd1 !== 9'(exp_mxn(i, 255, 2)) || bxn_rd1 !== 8'(exp_bxn(i, 255, 254, 2))) begin
        n_fail++; $display("FAIL p1_table idx=%0d got %0d/%0d want %0d/%0d", i, mxn_rd1, bxn_rd1,
          exp_mxn(i, 255, 2), exp_bxn(i, 255, 254, 2)); end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk); start = 1'b1; m = 8'd13; b = 8'd5;
    @(negedge clk); m = 8'd7; b = 8'd3;   // still high during CALC
    @(negedge clk); start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_chk++; if (lat !== 3) begin n_fail++;
      $display("FAIL ignore_latency got %0d want 3", lat); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(i, 13, 4)) || bxn_rd !== 8'(exp_bxn(i, 13, 5, 4))) begin
        n_fail++; $display("FAIL ignore_table idx=%0d got %0d/%0d want %0d/%0d", i, mxn_rd, bxn_rd,
          exp_mxn(i, 13, 4), exp_bxn(i, 13, 5, 4)); end
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    @(negedge clk); start = 1'b1; m = 8'd11; b = 8'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++; if ({busy, done, valid} !== 3'b000) begin n_fail++;
      $display("FAIL abort_flags got %b want 000", {busy, done, valid}); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'd0 || bxn_rd !== 8'd0) begin n_fail++;
        $display("FAIL abort_read idx=%0d got %0d/%0d want 0/0", i, mxn_rd, bxn_rd); end
    end
    @(negedge clk); rst_n = 1'b1;
    build0(13, 5, lat);
    n_chk++; if (lat !== 3 || valid !== 1'b1) begin n_fail++;
      $display("FAIL abort_rebuild got lat=%0d valid=%b want 3/1", lat, valid); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(i, 13, 4)) || bxn_rd !== 8'(exp_bxn(i, 13, 5, 4))) begin
        n_fail++; $display("FAIL abort_table idx=%0d got %0d/%0d want %0d/%0d", i, mxn_rd, bxn_rd,
          exp_mxn(i, 13, 4), exp_bxn(i, 13, 5, 4)); end
    end
  endtask

  task automatic test_b_zero;
    int lat;
    build0(13, 0, lat);
    n_chk++; if (lat !== 3) begin n_fail++;
      $display("FAIL bzero_latency got %0d want 3", lat); end
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(i, 13, 4)) || bxn_rd !== 8'd0) begin
        n_fail++; $display("FAIL bzero_table idx=%0d got %0d/%0d want %0d/0", i, mxn_rd, bxn_rd,
          exp_mxn(i, 13, 4)); end
    end
  endtask

  // random operands, each new start issued in the cycle done is high
  task automatic test_back_to_back;
    int mm, bb, pm, pb, lat, k;
    mm = $urandom_range(255, 1); bb = $urandom_range(mm - 1, 0);
    @(negedge clk); start = 1'b1; m = 8'(mm); b = 8'(bb);
    for (int n = 0; n < 16; n++) begin
      @(negedge clk); start = 1'b0; lat = 0;
      n_chk++; if (busy !== 1'b1 || valid !== 1'b0) begin n_fail++;
        $display("FAIL b2b_accept run=%0d got busy=%b valid=%b want 1/0", n, busy, valid); end
      while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      n_chk++; if (lat !== 3 || valid !== 1'b1) begin n_fail++;
        $display("FAIL b2b_latency run=%0d got lat=%0d valid=%b want 3/1", n, lat, valid); end
      pm = mm; pb = bb;
      k = $urandom_range(7, 0);
      rd_idx = 3'(k);
      if (n < 15) begin
        mm = $urandom_range(255, 1); bb = $urandom_range(mm - 1, 0);
        start = 1'b1; m = 8'(mm); b = 8'(bb);
      end
      #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(k, pm, 4)) || bxn_rd !== 8'(exp_bxn(k, pm, pb, 4))) begin
        n_fail++; $display("FAIL b2b_read run=%0d m=%0d b=%0d idx=%0d got %0d/%0d want %0d/%0d",
          n, pm, pb, k, mxn_rd, bxn_rd, exp_mxn(k, pm, 4), exp_bxn(k, pm, pb, 4)); end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1;
      n_chk++; if (mxn_rd !== 10'(exp_mxn(i, mm, 4)) || bxn_rd !== 8'(exp_bxn(i, mm, bb, 4))) begin
        n_fail++; $display("FAIL b2b_table idx=%0d got %0d/%0d want %0d/%0d", i, mxn_rd, bxn_rd,
          exp_mxn(i, mm, 4), exp_bxn(i, mm, bb, 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pbits1();
    test_ignore_start();
    test_reset_abort();
    test_b_zero();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_table_gen.md
MULT_TABLE_GEN -- requirements
Module: mult_table_gen

Interface
REQ-001 SHALL have parameter NBITS, default 256, meaning operand/modulus width.
REQ-002 SHALL have parameter PBITS, default 2, meaning digit width; table depth MLSIZE = 2^PBITS; legal range 1..6.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to build a new table, sampled on clk.
REQ-006 SHALL have port m  input  NBITS  modulus, captured on start acceptance.
REQ-007 SHALL have port b  input  NBITS  multiplicand, captured on start acceptance; b < m required.
REQ-008 SHALL have port busy  output  1  table build in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, table complete.
REQ-010 SHALL have port valid  output  1  table contents valid for the captured m, b.
REQ-011 SHALL have port rd_idx  input  PBITS+1  table read index 0..MLSIZE.
REQ-012 SHALL have port mxn_rd  output  NBITS+PBITS  rd_idx*m.
REQ-013 SHALL have port bxn_rd  output  NBITS  (rd_idx*b) mod m.

Function
REQ-014 SHALL implement states IDLE -> CALC -> IDLE; busy high exactly in CALC.
REQ-015 SHALL accept start only in IDLE; start in CALC SHALL be ignored with no effect on state, counter or table.
REQ-016 SHALL, on acceptance edge, capture m and b, clear valid, set busy, load index counter with 2.
REQ-017 SHALL write entry i (i = 2..MLSIZE) on the i-1th edge after acceptance: one entry per cycle, sequential accumulation only (no multipliers).
REQ-018 SHALL compute mxn entry i as mxn(i-1)+m, full NBITS+PBITS width, no truncation.
REQ-019 SHALL compute bxn entry i as bxn(i-1)+b followed by a single conditional subtraction of m (sum minus m kept iff non-negative); intermediate width NBITS+1.
REQ-020 SHALL hold entry 0 as zero and entry 1 as captured m / b (no cycle spent).
REQ-021 SHALL, on the edge writing entry MLSIZE, return to IDLE, drop busy, set valid, and pulse done high for exactly the following cycle; latency start-edge to done = MLSIZE-1 cycles (PBITS=1: 1 cycle).
REQ-022 SHALL drive mxn_rd/bxn_rd combinationally from rd_idx; rd_idx > MLSIZE SHALL return zero.
REQ-023 SHALL present current (possibly partial) contents when valid is low; consumers use valid.
REQ-024 SHALL accept start in the same cycle done is high (back-to-back builds).

Reset
REQ-025 SHALL, while rst_n low, force IDLE, busy=0, done=0, valid=0, counter=0, all table registers and captured m, b to zero; a reset during CALC SHALL abort the build.

Configuration
REQ-026 SHALL use macro MULT_TABLE_BXN_EN: defined, the b-multiple table, its adder and reducer are built as specified; undefined, no b registers exist and bxn_rd SHALL be tied to zero; mxn behaviour and timing unchanged.

Structure
REQ-027 SHALL place the state enum, MLSIZE derivation function and table-index type in package mult_table_pkg.
REQ-028 SHALL instantiate one sub-module mod_add_red (add plus conditional subtract of modulus, combinational) for the bxn path.

Verification
REQ-029 NBITS=8, PBITS=2, m=13, b=5, start -> done 3 cycles later; mxn 0,13,26,39,52; bxn 0,5,10,2,7; valid=1.
REQ-030 NBITS=8, PBITS=1, m=255, b=254 -> done after 1 cycle; mxn[2]=510, bxn[2]=253.
REQ-031 start re-pulsed with m=7 during CALC of m=13 build -> ignored; final table matches m=13.
REQ-032 rst_n low on cycle 2 of CALC -> busy/valid/done 0, all reads 0; fresh start afterwards builds correctly.
REQ-033 b=0, m=13 -> bxn all zero; rd_idx=7 at PBITS=2 -> mxn_rd=0, bxn_rd=0.
REQ-034 MULT_TABLE_BXN_EN undefined, repeat REQ-029 -> identical mxn and timing, bxn_rd constant 0.
